// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - mode encodings and helpers shared by the universal shift register
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DN   = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  function automatic logic mode_is_shift(input mode_t m);
    return (m == MODE_UP) || (m == MODE_DN);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one WIDTH-bit stage with a hold/up/down/load next-value mux
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  mode_t            mode_i,
  input  logic [WIDTH-1:0] up_i,
  input  logic [WIDTH-1:0] dn_i,
  input  logic [WIDTH-1:0] load_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      unique case (mode_i)
        MODE_UP:   data_d = up_i;
        MODE_DN:   data_d = dn_i;
        MODE_LOAD: data_d = load_i;
        default:   data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - bidirectional shift register with rotate, parallel load and fill tracking
module univ_shift_reg #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic                         rotate,
  input  logic [WIDTH-1:0]             sin_up,
  input  logic [WIDTH-1:0]             sin_dn,
  input  logic [DEPTH*WIDTH-1:0]       pload,
  output logic [DEPTH*WIDTH-1:0]       q,
  output logic [WIDTH-1:0]             sout_up,
  output logic [WIDTH-1:0]             sout_dn,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         full
);
  import shift_pkg::*;

  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

  mode_t            mode_w;
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] up_in   [DEPTH];
  logic [WIDTH-1:0] dn_in   [DEPTH];

  assign mode_w = mode_t'(mode);

  // The end stages pick between the serial input and the opposite end when rotating.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_up_end
      assign up_in[i] = rotate ? stage_q[DEPTH-1] : sin_up;
    end else begin : g_up_mid
      assign up_in[i] = stage_q[i-1];
    end

    if (i == DEPTH - 1) begin : g_dn_end
      assign dn_in[i] = rotate ? stage_q[0] : sin_dn;
    end else begin : g_dn_mid
      assign dn_in[i] = stage_q[i+1];
    end

    shift_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (en),
      .mode_i  (mode_w),
      .up_i    (up_in[i]),
      .dn_i    (dn_in[i]),
      .load_i  (pload[i*WIDTH +: WIDTH]),
      .q_o     (stage_q[i])
    );

    assign q[i*WIDTH +: WIDTH] = stage_q[i];
  end

  assign sout_up = stage_q[DEPTH-1];
  assign sout_dn = stage_q[0];

  logic [FW-1:0] fill_q;
  logic [FW-1:0] fill_d;
  logic          full_q;
  logic          full_d;

  // Only a non-rotating shift brings a new element in; rotation just recirculates.
  always_comb begin
    fill_d = fill_q;
    if (en) begin
      if (mode_w == MODE_LOAD) begin
        fill_d = DEPTH_F;
      end else if (mode_is_shift(mode_w) && !rotate && (fill_q != DEPTH_F)) begin
        fill_d = fill_q + FW'(1);
      end
    end
    full_d = (fill_d == DEPTH_F);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      full_q <= full_d;
    end
  end

  assign fill = fill_q;
  assign full = full_q;

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 1: bits per stage, legal range 1..32.
REQ-002 Parameter DEPTH, default 4: number of stages, legal range 2..64.
REQ-003 Port clk, input, 1: clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: reset, synchronous, active-high.
REQ-005 Port en, input, 1: operation enable; when 0, all state holds regardless of mode.
REQ-006 Port mode, input, 2: 00 hold, 01 shift-up, 10 shift-down, 11 parallel load.
REQ-007 Port rotate, input, 1: when 1 during a shift, the exiting stage re-enters at the opposite end instead of the serial input.
REQ-008 Port sin_up, input, WIDTH: serial input for shift-up; enters stage 0.
REQ-009 Port sin_dn, input, WIDTH: serial input for shift-down; enters stage DEPTH-1.
REQ-010 Port pload, input, DEPTH*WIDTH: parallel load data; stage i = pload[i*WIDTH +: WIDTH].
REQ-011 Port q, output, DEPTH*WIDTH: all stages, packed as for pload.
REQ-012 Port sout_up, output, WIDTH: stage DEPTH-1 contents.
REQ-013 Port sout_dn, output, WIDTH: stage 0 contents.
REQ-014 Port fill, output, clog2(DEPTH+1): count of valid stages.
REQ-015 Port full, output, 1: high when fill == DEPTH.

Function
REQ-016 Shift-up (en=1, mode=01): stage i <= stage i-1 for i>=1; stage 0 <= rotate ? stage DEPTH-1 : sin_up.
REQ-017 Shift-down (en=1, mode=10): stage i <= stage i+1 for i<=DEPTH-2; stage DEPTH-1 <= rotate ? stage 0 : sin_dn.
REQ-018 Parallel load (en=1, mode=11): every stage is loaded from pload in one cycle; rotate is ignored.
REQ-019 Hold (mode=00), or en=0: all stages and fill are unchanged.
REQ-020 Outputs q, sout_up, sout_dn and full are driven directly from registers, with no combinational path from any input.
REQ-021 Latency: data on sin_up appears on sout_up exactly DEPTH enabled shift-up cycles later; the same holds for sin_dn to sout_dn.
REQ-022 fill on a non-rotating shift: increments by 1 and saturates at DEPTH, with no wrap-around.
REQ-023 fill on a rotating shift or on hold: unchanged.
REQ-024 fill on parallel load: set to DEPTH.
REQ-025 full is a registered flag, updated in the same cycle as fill.
REQ-026 Reversing direction mid-stream is legal and does not alter fill; stage contents simply move in the new direction.

Reset
REQ-027 reset=1 at a rising clk edge: all stages <= 0, fill <= 0, full <= 0.
REQ-028 Reset overrides en and every mode, including reset asserted mid-shift or mid-load.
REQ-029 Power-up register contents before the first reset are undefined; verification starts only after reset.

Structure
REQ-030 Shared package shift_pkg holds the mode encodings: MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DN=2'b10, MODE_LOAD=2'b11.
REQ-031 One sub-module, shift_stage, is used: a WIDTH-bit register with a 4-way next-value mux (hold, up-neighbour, down-neighbour, load) and synchronous reset.
REQ-032 univ_shift_reg instantiates DEPTH shift_stage instances through a generate loop and owns the fill/full logic.

Verification (WIDTH=1, DEPTH=4 unless stated)
REQ-033 Serial shift-up: reset, then en=1, mode=01, sin_up=1,0,1,1 over 4 cycles -> q=4'b1011, fill=4, full=1; sout_up matches sin_up delayed 4 cycles.
REQ-034 Rotate: pload=4'b0001, mode=11, then 3 cycles mode=01 rotate=1 -> q=4'b1000, fill stays 4; one mode=10 rotate=1 cycle -> q=4'b0100.
REQ-035 Saturation and hold: 6 non-rotating shift-up cycles -> fill stays 4 with no wrap; then en=0 with mode=01 -> q and fill frozen.
REQ-036 Reset mid-operation: reset=1 asserted together with mode=11, pload=4'b1111 -> next cycle q=0, fill=0, full=0.
REQ-037 Wide variant, WIDTH=8, DEPTH=3: load 0xAA,0xBB,0xCC into stages 0..2, then mode=10 with sin_dn=0x11 -> stages = 0xBB,0xCC,0x11 and sout_dn=0xBB.
